uart_io_ctrl: RTL and testbench

//  Sequences the UART transmitter/receiver for the core's SENDB/RECVB instructions.

---
 rtl/uart_io_ctrl_if.sv | 11 +
 rtl/uart_io_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_io_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_io_ctrl_if.sv
// Core-side request/response bundle for the SENDB/RECVB byte sequencer.
interface uart_io_ctrl_if;
  logic       uart_go;
  logic       rors;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       uart_done;

  modport master (output uart_go, rors, wdata, input rdata, uart_done);
  modport slave  (input uart_go, rors, wdata, output rdata, uart_done);
endinterface

// File: rtl/uart_io_ctrl.sv
// Runs one UART byte send/receive per uart_go, RX bytes buffered in a FIFO; optional TX FIFO via UART_IO_TX_FIFO_EN.
// Latency: receive done 2 cycles after go when a byte is queued; send done after tx_busy falls (or after TX FIFO push).
// Backpressure: waits in RX_WAIT for data and in TX_ISSUE for an idle transmitter / free TX FIFO slot; full RX FIFO drops and flags rx_ovf.
module uart_io_ctrl #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  uart_io_ctrl_if.slave                 bus,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_busy,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic [$clog2(RX_DEPTH+1)-1:0] o_rx_level,
  output logic                          o_rx_ovf
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_LW = $clog2(RX_DEPTH + 1);

  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
    $error("RX_DEPTH must be a power of 2 and at least 2");
  end
  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
    $error("TX_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [2:0] {IDLE, RX_WAIT, TX_ISSUE, TX_ARM, TX_BUSY, DONE} state_t;

  state_t     r_state;
  logic [7:0] r_rdata;
  logic [7:0] r_tx_data;
  logic       r_done;
  logic       r_tx_start;
  logic       r_rx_ovf;

  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wptr;
  logic [RX_AW-1:0] r_rx_rptr;
  logic [RX_LW-1:0] r_rx_level;
  logic             w_rx_full;
  logic             w_rx_pop;
  logic             w_rx_push;

  // A push into a full FIFO is still accepted when the same cycle pops.
  assign w_rx_full = (r_rx_level == RX_LW'(RX_DEPTH));
  assign w_rx_pop  = (r_state == RX_WAIT) && (r_rx_level != '0);
  assign w_rx_push = i_rx_valid && (!w_rx_full || w_rx_pop);

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_level <= '0;
      r_rx_ovf   <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_level <= r_rx_level + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_level <= r_rx_level - 1'b1;
      if (i_rx_valid && !w_rx_push) r_rx_ovf <= 1'b1;
    end
  end

`ifdef UART_IO_TX_FIFO_EN
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_LW = $clog2(TX_DEPTH + 1);

  typedef enum logic {D_IDLE, D_ARM} drain_t;

  drain_t           r_dstate;
  logic [7:0]       r_wdata;
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wptr;
  logic [TX_AW-1:0] r_tx_rptr;
  logic [TX_LW-1:0] r_tx_level;
  logic             w_tx_full;
  logic             w_tx_push;
  logic             w_tx_pop;

  assign w_tx_full = (r_tx_level == TX_LW'(TX_DEPTH));
  assign w_tx_push = (r_state == TX_ISSUE) && !w_tx_full;
  assign w_tx_pop  = (r_dstate == D_IDLE) && (r_tx_level != '0) && !i_tx_busy;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_level <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_level <= r_tx_level + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_level <= r_tx_level - 1'b1;
    end
  end

  // D_ARM gives the transmitter a cycle to raise tx_busy before the next pop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dstate   <= D_IDLE;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_dstate)
        D_IDLE: if (w_tx_pop) begin
          r_tx_data  <= r_tx_mem[r_tx_rptr];
          r_tx_start <= 1'b1;
          r_dstate   <= D_ARM;
        end
        default: r_dstate <= D_IDLE;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_done  <= 1'b0;
`ifdef UART_IO_TX_FIFO_EN
      r_wdata <= '0;
`else
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifndef UART_IO_TX_FIFO_EN
      r_tx_start <= 1'b0;
`endif
      case (r_state)
        IDLE: if (bus.uart_go) begin
          if (bus.rors) begin
`ifdef UART_IO_TX_FIFO_EN
            r_wdata <= bus.wdata;
`else
            r_tx_data <= bus.wdata;
`endif
            r_state <= TX_ISSUE;
          end else begin
            r_state <= RX_WAIT;
          end
        end
        RX_WAIT: if (w_rx_pop) begin
          r_rdata <= r_rx_mem[r_rx_rptr];
          r_done  <= 1'b1;
          r_state <= DONE;
        end
`ifdef UART_IO_TX_FIFO_EN
        TX_ISSUE: if (!w_tx_full) begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
`else
        TX_ISSUE: if (!i_tx_busy) begin
          r_tx_start <= 1'b1;
          r_state    <= TX_ARM;
        end
`endif
        // tx_busy lags tx_start by one cycle, so TX_ARM must not sample it.
        TX_ARM: r_state <= TX_BUSY;
        TX_BUSY: if (!i_tx_busy) begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.uart_done = r_done;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_rx_level    = r_rx_level;
  assign o_rx_ovf      = r_rx_ovf;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: reference RX FIFO model plus expected-byte queues checked on uart_done/tx_start.
module tb_uart_io_ctrl;
  localparam int RX_DEPTH = 16;
  localparam int TX_DEPTH = 8;
  localparam int LW       = $clog2(RX_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic          i_tx_busy = 1'b0;
  logic [7:0]    i_rx_data = '0;
  logic          i_rx_valid = 1'b0;
  logic [LW-1:0] o_rx_level;
  logic          o_rx_ovf;

  uart_io_ctrl_if bus();

  uart_io_ctrl #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_level (o_rx_level),
    .o_rx_ovf   (o_rx_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int done_cycle = 0;
  int start_cycle = 0;
  int go_cycle = 0;
  logic prev_done = 1'b0;
  logic wait_rx = 1'b0;
  logic exp_ovf = 1'b0;

  logic [7:0] model_q [$];
  logic [7:0] rx_exp_q [$];
  logic [7:0] tx_exp_q [$];
  logic       op_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle++;

  // Scoreboard side: every done/tx_start is matched against what stimulus queued.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.uart_done) begin
        done_cnt++;
        done_cycle = cycle;
        check_eq("done_pulse_width", prev_done, 1'b0);
        if (op_q.size() == 0) begin
          check_eq("done_unexpected", 1'b1, 1'b0);
        end else if (op_q.pop_front() == 1'b0) begin
          if (rx_exp_q.size() == 0) check_eq("rx_exp_empty", 1'b1, 1'b0);
          else check_eq("rdata", bus.rdata, rx_exp_q.pop_front());
        end
      end
      if (o_tx_start) begin
        start_cnt++;
        start_cycle = cycle;
        check_eq("start_while_busy", i_tx_busy, 1'b0);
        if (tx_exp_q.size() == 0) check_eq("tx_start_unexpected", 1'b1, 1'b0);
        else check_eq("tx_data", o_tx_data, tx_exp_q.pop_front());
      end
    end
    prev_done = bus.uart_done;
  end

  task automatic go(input logic rors_i, input logic [7:0] wd);
    bus.uart_go = 1'b1;
    bus.rors    = rors_i;
    bus.wdata   = wd;
    go_cycle    = cycle;
    op_q.push_back(rors_i);
    if (rors_i) tx_exp_q.push_back(wd);
    else if (model_q.size() != 0) rx_exp_q.push_back(model_q.pop_front());
    else wait_rx = 1'b1;
    @(posedge clk); #1;
    bus.uart_go = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    if (model_q.size() < RX_DEPTH) model_q.push_back(b);
    else exp_ovf = 1'b1;
    if (wait_rx && model_q.size() != 0) begin
      rx_exp_q.push_back(model_q.pop_front());
      wait_rx = 1'b0;
    end
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq(tag, done_cnt != start, 1'b1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int start = start_cnt;
    int n = 0;
    while (start_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq(tag, start_cnt != start, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int s0;
    int fall;
    bus.uart_go = 1'b0;
    bus.rors    = 1'b0;
    bus.wdata   = '0;

    // Reset with receiver strobes arriving: nothing may be captured.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = 8'hE0 + 8'(i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("rst_rdata", bus.rdata, 8'h00);
    check_eq("rst_done", bus.uart_done, 1'b0);
    check_eq("rst_tx_data", o_tx_data, 8'h00);
    check_eq("rst_tx_start", o_tx_start, 1'b0);
    check_eq("rst_rx_level", o_rx_level, 0);
    check_eq("rst_rx_ovf", o_rx_ovf, 1'b0);
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_level", o_rx_level, 0);
    check_eq("post_rst_no_done", done_cnt, 0);

    // Three queued bytes come back in order; first receive takes two cycles.
    rx_push(8'h41);
    rx_push(8'h42);
    rx_push(8'h43);
    check_eq("level_3", o_rx_level, 3);
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 8'h00);
      wait_done("rx_done", 20);
      if (i == 0) check_eq("rx_latency", done_cycle - go_cycle, 2);
      check_eq("level_drain", o_rx_level, 2 - i);
    end

    // Receive issued on an empty FIFO waits for the byte.
    d0 = done_cnt;
    go(1'b0, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    check_eq("rx_wait_no_done", done_cnt, d0);
    s0 = cycle;
    rx_push(8'h5A);
    wait_done("rx_late_done", 20);
    check_eq("rx_late_latency", done_cycle - s0, 2);
    check_eq("rdata_held", bus.rdata, 8'h5A);

    // Fill to capacity, then pop and push in the same cycle, then overflow.
    for (int i = 0; i < RX_DEPTH; i++) rx_push(8'h10 + 8'(i));
    check_eq("level_full", o_rx_level, RX_DEPTH);
    check_eq("ovf_full_clear", o_rx_ovf, 1'b0);
    go(1'b0, 8'h00);
    rx_push(8'h99);
    wait_done("rx_full_pop_done", 20);
    check_eq("level_full_pushpop", o_rx_level, RX_DEPTH);
    check_eq("ovf_pushpop", o_rx_ovf, exp_ovf);
    rx_push(8'hEE);
    check_eq("level_after_drop", o_rx_level, RX_DEPTH);
    check_eq("ovf_set", o_rx_ovf, exp_ovf);
    for (int i = 0; i < RX_DEPTH; i++) begin
      go(1'b0, 8'h00);
      wait_done("rx_drain_done", 20);
    end
    check_eq("level_empty", o_rx_level, 0);
    check_eq("ovf_sticky", o_rx_ovf, 1'b1);

`ifndef UART_IO_TX_FIFO_EN
    // Send against a busy transmitter: start only once busy drops.
    i_tx_busy = 1'b1;
    s0 = start_cnt;
    d0 = done_cnt;
    go(1'b1, 8'hA5);
    repeat (10) @(posedge clk);
    #1;
    check_eq("tx_no_start_busy", start_cnt, s0);
    i_tx_busy = 1'b0;
    fall = cycle;
    wait_start("tx_start_seen", 10);
    check_eq("tx_start_latency", start_cycle - fall, 1);
    i_tx_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("tx_no_done_busy", done_cnt, d0);
    i_tx_busy = 1'b0;
    fall = cycle;
    wait_done("tx_done", 10);
    check_eq("tx_done_latency", done_cycle - fall, 1);
    check_eq("tx_start_once", start_cnt - s0, 1);

    // Idle transmitter: second byte goes straight through.
    go(1'b1, 8'h3C);
    wait_start("tx2_start_seen", 10);
    i_tx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_tx_busy = 1'b0;
    wait_done("tx2_done", 10);
    check_eq("tx2_start_once", start_cnt - s0, 2);
`else
    // Busy transmitter: TX FIFO absorbs TX_DEPTH sends, the next one stalls.
    i_tx_busy = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < TX_DEPTH; i++) begin
      go(1'b1, 8'hC0 + 8'(i));
      wait_done("txf_done", 10);
    end
    d0 = done_cnt;
    go(1'b1, 8'hC0 + 8'(TX_DEPTH));
    repeat (10) @(posedge clk);
    #1;
    check_eq("txf_stall", done_cnt, d0);
    check_eq("txf_no_start", start_cnt, s0);
    i_tx_busy = 1'b0;
    wait_done("txf_9th_done", 10);
    repeat (4 * TX_DEPTH) @(posedge clk);
    #1;
    check_eq("txf_all_started", start_cnt - s0, TX_DEPTH + 1);
`endif

    repeat (5) @(posedge clk);
    #1;
    check_eq("rx_exp_drained", rx_exp_q.size(), 0);
    check_eq("tx_exp_drained", tx_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
